// File: rtl/uart_rx_pkg.sv
// Shared types and register map constants for the uart_rx_buf receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam logic [31:0] DATA_OFS = 32'd0;
    localparam logic [31:0] STAT_OFS = 32'd8;
    localparam logic [31:0] CTRL_OFS = 32'd12;

    localparam int unsigned ST_NE   = 0;
    localparam int unsigned ST_FULL = 1;
    localparam int unsigned ST_OVR  = 2;
    localparam int unsigned ST_FERR = 3;
    localparam int unsigned ST_PERR = 4;

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO for received characters; pointers carry an extra wrap bit.
module rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        pop_ok;
    logic        push_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_ok)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_rx_buf.sv
// Memory-mapped UART receiver (8N1, 16x oversampled) with receive FIFO and IRQ.
// Define UART_RX_PARITY_EN for 8E1 framing with PERR detection.
module uart_rx_buf
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick16,
    input  logic        UART_RXD,
    input  logic [31:0] addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq_rx
);

    rx_state_e  state_q, state_d;
    logic       rx_s1_q, rx_s2_q;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic       ovr_q, ovr_d;
    logic       ferr_q, ferr_d;
    logic       ie_q, ie_d;
    logic       perr_bit;
    logic       frame_ok;
    logic       line;
    logic       push_req, ovr_set, ferr_set, perr_set;
    logic       sel_data, sel_stat, sel_ctrl;
    logic       rd_pop, wr_stat;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic       unused_wdata;

    assign line     = rx_s2_q;
    assign sel_data = (addr == BASE_ADDR + DATA_OFS);
    assign sel_stat = (addr == BASE_ADDR + STAT_OFS);
    assign sel_ctrl = (addr == BASE_ADDR + CTRL_OFS);
    assign rd_pop   = MemRead & sel_data;
    assign wr_stat  = MemWrite & sel_stat;
    assign unused_wdata = ^{wdata[31:5], wdata[4], wdata[1]};

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic par_bad_q, par_bad_d;
    assign perr_bit = perr_q;
    assign frame_ok = ~par_bad_q;
`else
    assign perr_bit = 1'b0;
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (tick16) begin
            case (state_q)
                IDLE: if (!line) begin
                    state_d = START;
                    cnt_d   = '0;
                end
                START: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = line ? IDLE : DATA;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        sh_d  = {line, sh_q[7:1]};
                        bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_q == 3'd7) state_d = PARITY;
`else
                        if (bit_q == 3'd7) state_d = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        par_bad_d = line ^ (^sh_q);
                        perr_set  = line ^ (^sh_q);
                        state_d   = STOP;
                    end
                end
`endif
                STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        if (!line) begin
                            ferr_set = 1'b1;
                            state_d  = WAIT_HIGH;
                        end else begin
                            push_req = frame_ok;
                        end
                    end
                end
                WAIT_HIGH: if (line) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // A completing byte is only lost when full and no read frees a slot this cycle.
    assign ovr_set = push_req & fifo_full & ~rd_pop;

    always_comb begin
        ovr_d  = ovr_set  | (ovr_q  & ~(wr_stat & wdata[ST_OVR]));
        ferr_d = ferr_set | (ferr_q & ~(wr_stat & wdata[ST_FERR]));
        ie_d   = (MemWrite & sel_ctrl) ? wdata[0] : ie_q;
`ifdef UART_RX_PARITY_EN
        perr_d = perr_set | (perr_q & ~(wr_stat & wdata[ST_PERR]));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ie_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rx_s1_q <= UART_RXD;
            rx_s2_q <= rx_s1_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            ie_q    <= ie_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_req),
        .din_i   (sh_q),
        .pop_i   (rd_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        rdata = '0;
        if (sel_data && !fifo_empty) begin
            rdata[7:0] = fifo_head;
        end else if (sel_stat) begin
            rdata[ST_NE]   = ~fifo_empty;
            rdata[ST_FULL] = fifo_full;
            rdata[ST_OVR]  = ovr_q;
            rdata[ST_FERR] = ferr_q;
            rdata[ST_PERR] = perr_bit;
        end else if (sel_ctrl) begin
            rdata[0] = ie_q;
        end
    end

    assign irq_rx = ie_q & ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed scoreboard bench for uart_rx_buf in its default 8N1 build.
module tb_uart_rx_buf;
    import uart_rx_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h4000_0018;
    localparam logic [31:0] A_DATA = BASE + DATA_OFS;
    localparam logic [31:0] A_STAT = BASE + STAT_OFS;
    localparam logic [31:0] A_CTRL = BASE + CTRL_OFS;

    logic        clk;
    logic        reset;
    logic        tick16;
    logic        UART_RXD;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq_rx;

    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;
    int         vectors;
    int         miscompares;

    uart_rx_buf #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick16   (tick16),
        .UART_RXD (UART_RXD),
        .addr     (addr),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq_rx   (irq_rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tick16 strobes every 4th clk, changed on the falling edge
    initial begin
        int unsigned tcnt;
        tcnt   = 0;
        tick16 = 1'b0;
        forever begin
            @(negedge clk);
            tcnt   = (tcnt + 1) % 4;
            tick16 = (tcnt == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before 400000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[ST_NE]   = (exp_q.size() != 0);
        s[ST_FULL] = (exp_q.size() == DEPTH);
        s[ST_OVR]  = exp_ovr;
        s[ST_FERR] = exp_ferr;
        return s;
    endfunction

    task automatic wait_tick(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick16 !== 1'b1);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, input logic pop, output logic [31:0] d);
        @(negedge clk);
        addr    = a;
        MemRead = pop;
        #1 d = rdata;
        @(posedge clk);
        #1 MemRead = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        addr     = a;
        wdata    = w;
        MemWrite = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(A_STAT, 1'b0, d);
        check(tag, d, exp_status());
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        bus_read(A_DATA, 1'b1, d);
        e = '0;
        if (exp_q.size() != 0) e[7:0] = exp_q.pop_front();
        check(tag, d, e);
    endtask

    // Stop bit is sampled on the 153rd tick after the start edge is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic chk_ne, input logic rd_at_stop);
        logic [31:0] d;
        logic [31:0] e;
        wait_tick(1);
        @(negedge clk) UART_RXD = 1'b0;
        wait_tick(16);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) UART_RXD = b[i];
            wait_tick(16);
        end
        @(negedge clk) UART_RXD = stop_bit;
        wait_tick(8);
        repeat (3) @(posedge clk);
        if (chk_ne) begin
            #1 addr = A_STAT;
            #1 check("ne_before_stop_sample", {31'b0, rdata[ST_NE]}, 32'd0);
        end else if (rd_at_stop) begin
            @(negedge clk);
            addr    = A_DATA;
            MemRead = 1'b1;
            #1 d = rdata;
            e = '0;
            if (exp_q.size() != 0) e[7:0] = exp_q.pop_front();
            check("read_at_stop", d, e);
        end
        @(posedge clk);
        #1 MemRead = 1'b0;
        if (chk_ne) check("ne_after_stop_sample", {31'b0, rdata[ST_NE]}, 32'd1);
        if (stop_bit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovr = 1'b1;
            wait_tick(8);
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d;
        vectors     = 0;
        miscompares = 0;
        exp_ovr     = 1'b0;
        exp_ferr    = 1'b0;
        reset       = 1'b0;
        UART_RXD    = 1'b1;
        addr        = '0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        wdata       = '0;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        check("reset_irq", {31'b0, irq_rx}, 32'd0);
        read_data("reset_data_empty");
        check_status("reset_status");
        bus_read(A_CTRL, 1'b0, d);
        check("reset_ctrl", d, 32'd0);
        bus_read(BASE + 32'd4, 1'b0, d);
        check("unmapped_read", d, 32'd0);

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        read_data("data_a5");
        check_status("status_after_a5");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        check_status("status_full_ovr");
        for (int i = 0; i < 5; i++) read_data("drain_after_ovr");
        check_status("status_ovr_only");
        bus_write(A_STAT, 32'h4);
        exp_ovr = 1'b0;
        check_status("status_ovr_cleared");

        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        wait_tick(40);
        check_status("status_ferr_held_low");
        @(negedge clk) UART_RXD = 1'b1;
        wait_tick(20);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        read_data("data_3c_after_break");
        bus_write(A_STAT, 32'h8);
        exp_ferr = 1'b0;
        check_status("status_ferr_cleared");

        wait_tick(1);
        @(negedge clk) UART_RXD = 1'b0;
        wait_tick(3);
        @(negedge clk) UART_RXD = 1'b1;
        wait_tick(30);
        check_status("status_after_glitch");
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        read_data("data_7e_after_glitch");

        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        check_status("status_full");
        send_frame(8'h14, 1'b1, 1'b0, 1'b1);
        check_status("status_full_no_ovr");
        for (int i = 0; i < 5; i++) read_data("drain_after_push_pop");

        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, 1'b0, d);
        check("ctrl_ie_set", d, 32'd1);
        check("irq_ie_empty", {31'b0, irq_rx}, 32'd0);
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        check("irq_one_queued", {31'b0, irq_rx}, 32'd1);
        read_data("data_99");
        check("irq_after_read", {31'b0, irq_rx}, 32'd0);

        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        check("irq_before_reset", {31'b0, irq_rx}, 32'd1);
        wait_tick(1);
        @(negedge clk) UART_RXD = 1'b0;
        wait_tick(16 + 16 * 3 + 5);
        @(negedge clk);
        reset    = 1'b0;
        UART_RXD = 1'b1;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        check("irq_after_reset", {31'b0, irq_rx}, 32'd0);
        check_status("status_after_midframe_reset");
        bus_read(A_CTRL, 1'b0, d);
        check("ctrl_after_reset", d, 32'd0);
        wait_tick(20);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        read_data("data_c3_after_reset");
        check_status("status_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
